// File: rtl/rand_pkg.sv
// rand_pkg -- shared types and default sizing for the randomness buffer.
//   rand_state_t : WARM (discarding warm-up words), RUN (buffering), HALT (health fault)
//   RAND_*       : default WIDTH / DEPTH / WARMUP / REP_LIMIT
package rand_pkg;
   localparam int RAND_WIDTH     = 63;
   localparam int RAND_DEPTH     = 4;
   localparam int RAND_WARMUP    = 2;
   localparam int RAND_REP_LIMIT = 3;

   typedef enum logic [1:0] {
      WARM = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } rand_state_t;
endpackage

// File: rtl/rand_buffer_if.sv
// rand_buffer_if -- PRNG side and consumer side of the randomness buffer.
//   prng_ren/prng_dout : read request, word returned one cycle later
//   flush              : drop buffered and in-flight words
//   rnd_valid/ready/data : head-word handshake to the masked consumer
//   level, fault       : occupancy and sticky health flag
// Modports: master = buffer, slave = PRNG + consumer environment.
interface rand_buffer_if
   import rand_pkg::*;
#(
   parameter int WIDTH = RAND_WIDTH,
   parameter int DEPTH = RAND_DEPTH
) ();
   localparam int LW = $clog2(DEPTH + 1);

   logic             prng_ren;
   logic [WIDTH-1:0] prng_dout;
   logic             flush;
   logic             rnd_valid;
   logic             rnd_ready;
   logic [WIDTH-1:0] rnd_data;
   logic [LW-1:0]    level;
   logic             fault;

   modport master (
      output prng_ren, rnd_valid, rnd_data, level, fault,
      input  prng_dout, flush, rnd_ready
   );

   modport slave (
      input  prng_ren, rnd_valid, rnd_data, level, fault,
      output prng_dout, flush, rnd_ready
   );
endinterface

// File: rtl/rand_fifo.sv
// rand_fifo -- word storage for rand_buffer.
//   clk, rst_n (sync, active-low), clear (flush, beats push/pop),
//   push/din write, pop advances head, head = oldest word, level = count.
// Storage is not reset; the parent never exposes head while level==0.
module rand_fifo
   import rand_pkg::*;
#(
   parameter int WIDTH = RAND_WIDTH,
   parameter int DEPTH = RAND_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && rst_n && !clear) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/rand_buffer.sv
// rand_buffer -- prefetches PRNG words into a small FIFO for a masked consumer.
//   clk, rst_n (sync, active-low), bus (rand_buffer_if.master).
// After reset WARMUP returned words are discarded, then words are captured
// into rand_fifo and handed out once each. Optional health test under the
// macro RAND_HEALTH_EN: a repeated word (REP_LIMIT in a row) or an all-zero
// word moves the block to HALT until reset.
module rand_buffer
   import rand_pkg::*;
#(
   parameter int WIDTH     = RAND_WIDTH,
   parameter int DEPTH     = RAND_DEPTH,
   parameter int WARMUP    = RAND_WARMUP,
   parameter int REP_LIMIT = RAND_REP_LIMIT
) (
   input  logic          clk,
   input  logic          rst_n,
   rand_buffer_if.master bus
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int SW = LW + 1;
   localparam int WW = $clog2(WARMUP + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WARMUP < 1 || REP_LIMIT < 2) begin : g_param_check
      $error("rand_buffer: unsupported DEPTH/WARMUP/REP_LIMIT");
   end

   rand_state_t      state;
   logic             pend;
   logic [WW-1:0]    warm_cnt;
   logic             ren;
   logic             pop;
   logic             capture;
   logic             trip;
   logic [WIDTH-1:0] head;
   logic [LW-1:0]    level;
   logic [SW-1:0]    fill;

   assign pop     = bus.rnd_valid && bus.rnd_ready;
   assign capture = pend && (state == RUN) && !bus.flush;

   // A pop frees a slot this cycle but also consumes one, so it cancels out:
   // request only while the buffered plus in-flight words leave a free slot.
   assign fill = SW'(level) + SW'(pend);

   always_comb begin
      ren = 1'b0;
      if (rst_n) begin
         case (state)
            WARM:    ren = 1'b1;
            RUN:     ren = (fill <= SW'(DEPTH - 1));
            default: ren = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= WARM;
         pend     <= 1'b0;
         warm_cnt <= '0;
      end else begin
         pend <= ren && !bus.flush;
         if (state == WARM && pend && !bus.flush) begin
            if (warm_cnt == WW'(WARMUP - 1)) state    <= RUN;
            else                             warm_cnt <= warm_cnt + WW'(1);
         end
         if (trip) state <= HALT;
      end
   end

   rand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (bus.flush),
      .push  (capture),
      .pop   (pop),
      .din   (bus.prng_dout),
      .head  (head),
      .level (level)
   );

`ifdef RAND_HEALTH_EN
   localparam int RW = $clog2(REP_LIMIT + 1);

   logic [WIDTH-1:0] prev;
   logic [RW-1:0]    rep_cnt;
   logic [RW-1:0]    rep_nxt;

   // rep_cnt==0 means no word captured yet, so the first word starts a run of 1
   assign rep_nxt = (rep_cnt != '0 && bus.prng_dout == prev) ? rep_cnt + RW'(1) : RW'(1);
   assign trip    = capture && (bus.prng_dout == '0 || rep_nxt >= RW'(REP_LIMIT));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rep_cnt <= '0;
         prev    <= '0;
      end else if (capture) begin
         rep_cnt <= rep_nxt;
         prev    <= bus.prng_dout;
      end
   end

   assign bus.fault = (state == HALT);
`else
   assign trip      = 1'b0;
   assign bus.fault = 1'b0;
`endif

   assign bus.prng_ren  = ren;
   assign bus.level     = level;
   assign bus.rnd_valid = (state == RUN) && (level != '0);
   assign bus.rnd_data  = bus.rnd_valid ? head : '0;
endmodule

// File: tb/tb_rand_buffer.sv
// tb_rand_buffer -- directed bench for rand_buffer with a counting PRNG stub.
// PRNG word k (k = 1, 2, ...) is word_of(k); force_en substitutes force_val.
module tb_rand_buffer;
   import rand_pkg::*;

   localparam int WIDTH = 63;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks    = 0;
   int   failures  = 0;
   int   prng_cnt  = 0;
   int   delivered = 0;
   logic             force_en;
   logic [WIDTH-1:0] force_val;

   always #5 clk = ~clk;

   rand_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   rand_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WARMUP(2), .REP_LIMIT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [WIDTH-1:0] word_of(input int k);
      return WIDTH'(64'h0ABC_0000) + WIDTH'(k);
   endfunction

   // PRNG stub: word appears on prng_dout the cycle after the request
   initial bus.prng_dout = '0;
   always @(posedge clk) begin
      if (bus.prng_ren) begin
         prng_cnt      <= prng_cnt + 1;
         bus.prng_dout <= force_en ? force_val : word_of(prng_cnt + 1);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.flush     = 1'b0;
      bus.rnd_ready = 1'b0;
      force_en      = 1'b0;
      force_val     = '0;
      repeat (2) @(posedge clk);
      #1;
      mid();
      chk("rst_level", 64'(bus.level), 0);
      chk("rst_valid", 64'(bus.rnd_valid), 0);
      chk("rst_data", 64'(bus.rnd_data), 0);
      chk("rst_fault", 64'(bus.fault), 0);
      chk("rst_ren", 64'(bus.prng_ren), 0);
      cyc();
      rst_n = 1'b1;                       // cycle c0

      // warm-up: words 1,2 dropped, word 3 is first captured
      repeat (4) cyc();                   // c4
      mid();
      chk("first_level", 64'(bus.level), 1);
      chk("first_word", 64'(bus.rnd_data), 64'(word_of(3)));
      repeat (3) cyc();                   // c7
      mid();
      chk("fill_level", 64'(bus.level), 4);
      chk("fill_ren", 64'(bus.prng_ren), 0);
      repeat (3) cyc();
      mid();
      chk("full_ren_hold", 64'(bus.prng_ren), 0);
      chk("full_prng_cnt", 64'(prng_cnt), 6);

      // streaming with ready held: one word per cycle, in PRNG order
      cyc();
      bus.rnd_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         mid();
         if (bus.rnd_valid && bus.rnd_ready) delivered++;
         chk($sformatf("stream_%0d", i), 64'(bus.rnd_data), 64'(word_of(3 + i)));
         cyc();
      end
      bus.rnd_ready = 1'b0;
      mid();
      chk("stream_count", 64'(delivered), 20);
      repeat (3) cyc();
      mid();
      chk("refill_level", 64'(bus.level), 4);
      chk("refill_head", 64'(bus.rnd_data), 64'(word_of(23)));
      chk("refill_prng_cnt", 64'(prng_cnt), 26);

      // drain to level 2, then push and pop together
      cyc();
      bus.rnd_ready = 1'b1;
      mid();
      chk("p1_head", 64'(bus.rnd_data), 64'(word_of(23)));
      cyc();
      mid();
      chk("p2_level", 64'(bus.level), 3);
      chk("p2_ren", 64'(bus.prng_ren), 1);
      chk("p2_head", 64'(bus.rnd_data), 64'(word_of(24)));
      cyc();
      mid();
      chk("pp_level_before", 64'(bus.level), 2);
      chk("pp_head_before", 64'(bus.rnd_data), 64'(word_of(25)));
      cyc();
      bus.rnd_ready = 1'b0;
      mid();
      chk("pp_level_after", 64'(bus.level), 2);
      chk("pp_head_after", 64'(bus.rnd_data), 64'(word_of(26)));

      // flush at level 3 while word 29 is pending
      cyc();
      bus.flush = 1'b1;
      mid();
      chk("flush_level_before", 64'(bus.level), 3);
      cyc();
      bus.flush = 1'b0;
      mid();
      chk("flush_level", 64'(bus.level), 0);
      chk("flush_valid", 64'(bus.rnd_valid), 0);
      chk("flush_data", 64'(bus.rnd_data), 0);
      repeat (6) cyc();
      mid();
      chk("flush_refill_level", 64'(bus.level), 4);
      chk("flush_drop_head", 64'(bus.rnd_data), 64'(word_of(30)));

      // one-cycle reset at level 3: warm-up repeats (words 34,35 dropped)
      cyc();
      bus.rnd_ready = 1'b1;
      mid();
      chk("q1_head", 64'(bus.rnd_data), 64'(word_of(30)));
      cyc();
      bus.rnd_ready = 1'b0;
      rst_n = 1'b0;
      mid();
      chk("pre_reset_level", 64'(bus.level), 3);
      chk("in_reset_ren", 64'(bus.prng_ren), 0);
      cyc();
      rst_n = 1'b1;
      mid();
      chk("rerst_level", 64'(bus.level), 0);
      chk("rerst_valid", 64'(bus.rnd_valid), 0);
      chk("rerst_data", 64'(bus.rnd_data), 0);
      repeat (4) cyc();
      mid();
      chk("rewarm_level", 64'(bus.level), 1);
      chk("rewarm_first", 64'(bus.rnd_data), 64'(word_of(36)));

`ifdef RAND_HEALTH_EN
      // repeated word: captures in c3,c4,c5, HALT from c6
      force_en  = 1'b1;
      force_val = WIDTH'(64'h123);
      do_reset();
      repeat (5) cyc();
      mid();
      chk("rep_fault_before", 64'(bus.fault), 0);
      cyc();
      mid();
      chk("rep_fault", 64'(bus.fault), 1);
      chk("rep_ren", 64'(bus.prng_ren), 0);
      chk("rep_valid", 64'(bus.rnd_valid), 0);
      chk("rep_data", 64'(bus.rnd_data), 0);
      cyc();
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      mid();
      chk("fault_through_flush", 64'(bus.fault), 1);
      repeat (3) cyc();
      mid();
      chk("halt_sticky", 64'(bus.fault), 1);

      // all-zero word: first capture in c3, fault in c4
      force_val = '0;
      do_reset();
      mid();
      chk("zero_rst_fault", 64'(bus.fault), 0);
      repeat (3) cyc();
      mid();
      chk("zero_fault_before", 64'(bus.fault), 0);
      cyc();
      mid();
      chk("zero_fault", 64'(bus.fault), 1);
      chk("zero_ren", 64'(bus.prng_ren), 0);
`else
      // without the health test repeated and zero words are buffered normally
      force_en  = 1'b1;
      force_val = WIDTH'(64'h123);
      do_reset();
      repeat (10) cyc();
      mid();
      chk("nohealth_fault", 64'(bus.fault), 0);
      chk("nohealth_valid", 64'(bus.rnd_valid), 1);
      chk("nohealth_data", 64'(bus.rnd_data), 64'h123);
      force_val = '0;
      do_reset();
      repeat (10) cyc();
      mid();
      chk("nohealth_zero_fault", 64'(bus.fault), 0);
      chk("nohealth_zero_level", 64'(bus.level), 4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rand_buffer.md
RAND_BUFFER -- requirements
Module: rand_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 63: randomness word width, equal to the upstream PRNG OUTLENGTH.
REQ-002 SHALL have parameter DEPTH, default 4: number of buffered words, a power of two and at least 2.
REQ-003 SHALL have parameter WARMUP, default 2: number of PRNG words discarded after reset.
REQ-004 SHALL have parameter REP_LIMIT, default 3: count of consecutive identical accepted words that trips the health fault.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 prng_ren  output  1  read request to the PRNG; that word appears on prng_dout one cycle later.
REQ-008 prng_dout  input  WIDTH  PRNG output word.
REQ-009 flush  input  1  discards all buffered and in-flight words (permutation start).
REQ-010 rnd_valid  output  1  head word available to the masked consumer.
REQ-011 rnd_ready  input  1  consumer accepts the head word.
REQ-012 rnd_data  output  WIDTH  head word.
REQ-013 level  output  $clog2(DEPTH+1)  count of buffered words.
REQ-014 fault  output  1  sticky health failure flag.

Function
REQ-015 States SHALL be WARM, RUN and HALT.
REQ-016 WARM SHALL issue prng_ren every cycle and discard each returned word; the block SHALL enter RUN after WARMUP words are returned.
REQ-017 A returned word SHALL be tracked by a pending bit: set in the cycle after prng_ren=1, and the word is captured from prng_dout while the bit is set.
REQ-018 In RUN, prng_ren SHALL be 1 iff level + pending + (1 if a pop occurs this cycle) <= DEPTH - 1 + (1 if a pop occurs this cycle), so that no captured word ever overflows the buffer.
REQ-019 A pop SHALL occur iff rnd_valid && rnd_ready.
REQ-020 Push and pop in the same cycle SHALL leave level unchanged.
REQ-021 The buffer SHALL be first-in first-out, with read and write pointers wrapping modulo DEPTH.
REQ-022 rnd_valid SHALL equal (state==RUN && level!=0).
REQ-023 rnd_data SHALL be the head word when rnd_valid=1, and all-zero otherwise; randomness is never exposed unvalidated.
REQ-024 No word SHALL be delivered twice; a popped word is unrecoverable.
REQ-025 flush SHALL take priority over push and pop; the next cycle has level=0, pointers reset, and any pending word dropped; the state is unchanged.
REQ-026 When level=DEPTH and pending=0, prng_ren SHALL be 0.
REQ-027 Sustained throughput with rnd_ready held at 1 SHALL be one word per cycle after the first fill.

Reset
REQ-028 With rst_n=0 at a clock edge, the following SHALL hold, including mid-operation: state=WARM, level=0, pointers=0, pending=0, warm-up count=0, repetition count=0, prng_ren=0, rnd_valid=0, rnd_data=0, fault=0.
REQ-029 Buffer storage contents need not be reset, but they SHALL never reach rnd_data before being rewritten.

Configuration
REQ-030 With RAND_HEALTH_EN defined, each word captured in RUN SHALL be compared with the previous captured word.
REQ-031 With RAND_HEALTH_EN defined, REP_LIMIT consecutive identical captured words, or any all-zero captured word, SHALL move the block to HALT in the next cycle.
REQ-032 In HALT: fault=1, rnd_valid=0, prng_ren=0, and the block leaves HALT only on reset.
REQ-033 flush SHALL not clear fault.
REQ-034 Without RAND_HEALTH_EN, fault SHALL be constant 0, HALT SHALL be unreachable, and the comparator logic SHALL be absent.

Structure
REQ-035 Package rand_pkg SHALL hold the state enum type and the default constants for WIDTH, DEPTH, WARMUP and REP_LIMIT.
REQ-036 Storage and pointers SHALL live in sub-module rand_fifo (push, pop, clear, head data, level); rand_buffer holds the FSM, pending tracking and health test.

Verification
REQ-037 Reset, then rnd_ready=0 with a real PRNG: first 2 returned words dropped; level reaches 4 and prng_ren then stays 0; popped rnd_data equals PRNG words 3,4,5,6 in order.
REQ-038 Full buffer, then rnd_ready=1 for 20 cycles: exactly 20 words delivered, contiguous in PRNG order, with no gap and no repeat.
REQ-039 Level 2 with a push and a pop in the same cycle: level stays 2 and head advances one word.
REQ-040 flush asserted in the cycle a word is pending, with level 3: next cycle level=0, rnd_valid=0, rnd_data=0, and the pending word never appears.
REQ-041 RAND_HEALTH_EN, prng_dout forced to 0x123 in RUN: fault=1 after the 3rd identical capture, prng_ren=0, and fault stays 1 through flush; a forced 0 word trips fault one cycle after capture.
REQ-042 rst_n=0 for one cycle at level 3: level=0, rnd_valid=0, and WARM re-entered with 2 words discarded again.
